// File: rtl/me_search_ctrl_pkg.sv
// rtl/me_search_ctrl_pkg.sv - shared types and helpers for the motion-estimation scheduler
// Optional early termination is selected by ME_EARLY_TERM_EN in the interface and top.
package me_pkg;

  localparam int MV_MAX_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} me_state_t;

  typedef struct packed {
    logic signed [MV_MAX_W-1:0] dx;
    logic signed [MV_MAX_W-1:0] dy;
  } mv_t;

  function automatic int cand_count(input int r);
    return (2 * r + 1) * (2 * r + 1);
  endfunction

endpackage

// File: rtl/me_search_ctrl_if.sv
// rtl/me_search_ctrl_if.sv - start/candidate/SAD/result bundle for me_search_ctrl
// early_thresh exists only when ME_EARLY_TERM_EN is defined.
interface me_search_ctrl_if #(
  parameter int SEARCH_RANGE = 8,
  parameter int SAD_W        = 16
);
  localparam int MV_W = $clog2(2 * SEARCH_RANGE + 1) + 1;

  logic                    start;
  logic                    busy;
  logic                    cand_valid;
  logic                    cand_ready;
  logic signed [MV_W-1:0]  cand_dx;
  logic signed [MV_W-1:0]  cand_dy;
  logic                    sad_valid;
  logic [SAD_W-1:0]        sad;
  logic                    done;
  logic signed [MV_W-1:0]  best_dx;
  logic signed [MV_W-1:0]  best_dy;
  logic [SAD_W-1:0]        best_sad;
`ifdef ME_EARLY_TERM_EN
  logic [SAD_W-1:0]        early_thresh;
`endif

  modport master (
    input  start, cand_ready, sad_valid, sad,
`ifdef ME_EARLY_TERM_EN
    input  early_thresh,
`endif
    output busy, cand_valid, cand_dx, cand_dy, done, best_dx, best_dy, best_sad
  );

  modport slave (
    output start, cand_ready, sad_valid, sad,
`ifdef ME_EARLY_TERM_EN
    output early_thresh,
`endif
    input  busy, cand_valid, cand_dx, cand_dy, done, best_dx, best_dy, best_sad
  );

endinterface

// File: rtl/me_search_ctrl_best_tracker.sv
// rtl/me_search_ctrl_best_tracker.sv - registered running minimum of SAD with its vector tag
// First result after clear loads unconditionally; later ones need a strictly smaller SAD.
module me_best_tracker
  import me_pkg::*;
#(
  parameter int  SAD_W = 16,
  parameter type tag_t = mv_t
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_first_i,
  input  logic             sad_valid_i,
  input  logic [SAD_W-1:0] sad_i,
  input  tag_t             tag_i,
  output logic [SAD_W-1:0] best_sad_o,
  output tag_t             best_mv_o
);

  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  tag_t             best_mv_q, best_mv_d;

  always_comb begin
    best_sad_d = best_sad_q;
    best_mv_d  = best_mv_q;
    if (clear_i) begin
      best_sad_d = '1;
      best_mv_d  = '0;
    end else if (sad_valid_i && (load_first_i || (sad_i < best_sad_q))) begin
      best_sad_d = sad_i;
      best_mv_d  = tag_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_sad_q <= '1;
      best_mv_q  <= '0;
    end else begin
      best_sad_q <= best_sad_d;
      best_mv_q  <= best_mv_d;
    end
  end

  assign best_sad_o = best_sad_q;
  assign best_mv_o  = best_mv_q;

endmodule

// File: rtl/me_search_ctrl.sv
// rtl/me_search_ctrl.sv - full-search motion-vector scheduler with in-order SAD minimum tracking
// Define ME_EARLY_TERM_EN to stop issuing once a processed SAD is at or below early_thresh.
module me_search_ctrl
  import me_pkg::*;
#(
  parameter int SEARCH_RANGE    = 8,
  parameter int SAD_W           = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  me_search_ctrl_if.master bus
);

  localparam int MV_W  = $clog2(2 * SEARCH_RANGE + 1) + 1;
  localparam int NCAND = cand_count(SEARCH_RANGE);
  localparam int CNT_W = $clog2(NCAND + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic signed [MV_W-1:0] dx;
    logic signed [MV_W-1:0] dy;
  } vec_t;

  localparam logic signed [MV_W-1:0] R_POS   = MV_W'(SEARCH_RANGE);
  localparam logic signed [MV_W-1:0] R_NEG   = -R_POS;
  localparam logic signed [MV_W-1:0] MV_ONE  = MV_W'(1);
  localparam logic [OUT_W-1:0]       OUT_MAX = OUT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]       LAST    = CNT_W'(NCAND - 1);

  me_state_t        state_q, state_d;
  vec_t             iss_q, iss_d, res_q, res_d;
  logic [CNT_W-1:0] iss_cnt_q, iss_cnt_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             res_first_q, res_first_d;
  logic             cand_valid, iss_fire, res_fire, start_ok, last_iss, early_stop;
  vec_t             best_mv;

  // Raster step shared by the issue and result counters: dx inner, dy outer.
  function automatic vec_t raster_next(input vec_t v);
    vec_t n;
    n = v;
    if (v.dx == R_POS) begin
      n.dx = R_NEG;
      n.dy = v.dy + MV_ONE;
    end else begin
      n.dx = v.dx + MV_ONE;
    end
    return n;
  endfunction

  always_comb begin
    state_d     = state_q;
    iss_d       = iss_q;
    res_d       = res_q;
    iss_cnt_d   = iss_cnt_q;
    out_d       = out_q;
    res_first_d = res_first_q;

    cand_valid = (state_q == ISSUE) && (out_q < OUT_MAX);
    iss_fire   = cand_valid && bus.cand_ready;
    res_fire   = bus.sad_valid && (out_q != '0);
    start_ok   = (state_q == IDLE) && bus.start;
    last_iss   = iss_fire && (iss_cnt_q == LAST);
`ifdef ME_EARLY_TERM_EN
    early_stop = res_fire && (bus.sad <= bus.early_thresh);
`else
    early_stop = 1'b0;
`endif

    if (iss_fire && !res_fire) begin
      out_d = out_q + 1'b1;
    end else if (!iss_fire && res_fire) begin
      out_d = out_q - 1'b1;
    end
    if (iss_fire) begin
      iss_d     = raster_next(iss_q);
      iss_cnt_d = iss_cnt_q + 1'b1;
    end
    if (res_fire) begin
      res_d       = raster_next(res_q);
      res_first_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d     = ISSUE;
          iss_d       = '{dx: R_NEG, dy: R_NEG};
          res_d       = '{dx: R_NEG, dy: R_NEG};
          iss_cnt_d   = '0;
          res_first_d = 1'b1;
        end
      end
      ISSUE: begin
        // An early stop with nothing in flight has no drain to wait for.
        if (last_iss || early_stop) begin
          state_d = (out_d == '0) ? DONE : DRAIN;
        end
      end
      DRAIN:   if (out_d == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      iss_q       <= '0;
      res_q       <= '0;
      iss_cnt_q   <= '0;
      out_q       <= '0;
      res_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      iss_q       <= iss_d;
      res_q       <= res_d;
      iss_cnt_q   <= iss_cnt_d;
      out_q       <= out_d;
      res_first_q <= res_first_d;
    end
  end

  me_best_tracker #(
    .SAD_W (SAD_W),
    .tag_t (vec_t)
  ) u_best (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (start_ok),
    .load_first_i (res_first_q),
    .sad_valid_i  (res_fire),
    .sad_i        (bus.sad),
    .tag_i        (res_q),
    .best_sad_o   (bus.best_sad),
    .best_mv_o    (best_mv)
  );

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.cand_valid = cand_valid;
  assign bus.cand_dx    = iss_q.dx;
  assign bus.cand_dy    = iss_q.dy;
  assign bus.best_dx    = best_mv.dx;
  assign bus.best_dy    = best_mv.dy;

endmodule
